// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding an
// in-order response queue, with flush and a boot-time load port.
module imem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    input  logic [31:0]                  req_addr,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [31:0]                  resp_data,
    output logic [31:0]                  resp_addr,
    output logic                         resp_err,
    input  logic                         resp_ready,
    input  logic                         flush,
    input  logic                         load_en,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int QW = $clog2(DEPTH);
    localparam int CW = QW + 1;

    logic [31:0]        mem [MEM_WORDS];

    logic [LATENCY-1:0] p_vld;
    logic [31:0]        p_addr [LATENCY];
    logic [31:0]        p_data [LATENCY];
    logic               p_err  [LATENCY];

    logic [31:0]        q_addr [DEPTH];
    logic [31:0]        q_data [DEPTH];
    logic               q_err  [DEPTH];

    logic [QW-1:0]      wptr;
    logic [QW-1:0]      rptr;
    logic [CW-1:0]      qcnt;
    logic [CW-1:0]      count;

    logic               accept;
    logic               pop;
    logic               push;
    logic               rd_err;
    logic [31:0]        rd_word;

    assign req_ready = (count < CW'(DEPTH)) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;
    assign push      = p_vld[LATENCY-1];

    assign rd_err  = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign rd_word = rd_err ? 32'h0 : mem[req_addr[AW+1:2]];

    // Outputs read straight from the queue head so they stay put while stalled.
    assign resp_valid = (qcnt != '0);
    assign resp_data  = resp_valid ? q_data[rptr] : 32'h0;
    assign resp_addr  = resp_valid ? q_addr[rptr] : 32'h0;
    assign resp_err   = resp_valid ? q_err[rptr]  : 1'b0;

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // Payload registers carry no reset; the valid bits below qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            p_addr[0] <= req_addr;
            p_data[0] <= rd_word;
            p_err[0]  <= rd_err;
        end
        for (int i = 1; i < LATENCY; i++) begin
            p_addr[i] <= p_addr[i-1];
            p_data[i] <= p_data[i-1];
            p_err[i]  <= p_err[i-1];
        end
        if (push) begin
            q_addr[wptr] <= p_addr[LATENCY-1];
            q_data[wptr] <= p_data[LATENCY-1];
            q_err[wptr]  <= p_err[LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_vld <= '0;
            wptr  <= '0;
            rptr  <= '0;
            qcnt  <= '0;
            count <= '0;
        end else if (flush) begin
            p_vld <= '0;
            wptr  <= '0;
            rptr  <= '0;
            qcnt  <= '0;
            count <= '0;
        end else begin
            p_vld[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                p_vld[i] <= p_vld[i-1];
            end
            if (push) begin
                wptr <= wptr + QW'(1);
            end
            if (pop) begin
                rptr <= rptr + QW'(1);
            end
            unique case ({push, pop})
                2'b10:   qcnt <= qcnt + CW'(1);
                2'b01:   qcnt <= qcnt - CW'(1);
                default: qcnt <= qcnt;
            endcase
            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, streaming, backpressure,
// errors, flush, async reset and load/read collision.
module tb_imem_responder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_data;
    logic [31:0]   resp_addr;
    logic          resp_err;
    logic          resp_ready;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    int vecs = 0;
    int errs = 0;

    logic [31:0] exp_w [4];

    imem_responder #(.MEM_WORDS(1024), .LATENCY(2), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .flush      (flush),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] d,
                               input logic [31:0] a, input logic e);
        int n = 0;
        while (!resp_valid && n < 10) begin
            step();
            n++;
        end
        check({tag, "_v"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_d"}, resp_data, d);
        check({tag, "_a"}, resp_addr, a);
        check({tag, "_e"}, {31'b0, resp_err}, {31'b0, e});
        step();
    endtask

    initial begin
        exp_w[0] = 32'h11;
        exp_w[1] = 32'h22;
        exp_w[2] = 32'h33;
        exp_w[3] = 32'h44;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        repeat (2) step();
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_addr", resp_addr, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) load_word(AW'(i), exp_w[i]);

        // basic latency
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        step();
        req_valid = 1'b0;
        check("lat_n0", {31'b0, resp_valid}, 32'd0);
        step();
        check("lat_n1", {31'b0, resp_valid}, 32'd0);
        step();
        check("lat_v", {31'b0, resp_valid}, 32'd1);
        check("lat_d", resp_data, 32'h22);
        check("lat_a", resp_addr, 32'h4);
        check("lat_e", {31'b0, resp_err}, 32'd0);
        step();
        check("lat_gone", {31'b0, resp_valid}, 32'd0);

        // streaming
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                req_valid = 1'b1;
                req_addr  = 32'(4 * k);
                check("str_rdy", {31'b0, req_ready}, 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            step();
            if (k >= 2) begin
                check("str_v", {31'b0, resp_valid}, 32'd1);
                check("str_d", resp_data, exp_w[k-2]);
            end
        end
        step();
        check("str_end", {31'b0, resp_valid}, 32'd0);

        // backpressure / full
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * i);
            check("bp_acc", {31'b0, req_ready}, 32'd1);
            step();
        end
        req_addr = 32'h0;
        check("bp_full", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_full_h", {31'b0, req_ready}, 32'd0);
            check("bp_head", resp_data, 32'h11);
            check("bp_hv", {31'b0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        step();
        check("bp_ready_back", {31'b0, req_ready}, 32'd1);
        check("bp_h1", resp_data, 32'h22);
        step();
        check("bp_h2", resp_data, 32'h33);
        req_addr = 32'h4;
        check("bp_acc5", {31'b0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("bp_h3", resp_data, 32'h44);
        step();
        check("bp_h4", resp_data, 32'h11);
        check("bp_a4", resp_addr, 32'h0);
        step();
        check("bp_h5", resp_data, 32'h22);
        check("bp_a5", resp_addr, 32'h4);
        step();
        check("bp_empty", {31'b0, resp_valid}, 32'd0);

        // address faults
        req_valid = 1'b1;
        req_addr  = 32'h2;
        step();
        req_addr  = 32'h1000;
        step();
        req_valid = 1'b0;
        expect_resp("err_mis", 32'h0, 32'h2, 1'b1);
        expect_resp("err_oob", 32'h0, 32'h1000, 1'b1);

        // flush
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * i);
            step();
        end
        flush    = 1'b1;
        req_addr = 32'hC;
        #1;
        check("fl_rdy", {31'b0, req_ready}, 32'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("fl_cnt", 32'(dut.count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("fl_stale", {31'b0, resp_valid}, 32'd0);
            step();
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h8;
        step();
        req_valid = 1'b0;
        check("fl_n0", {31'b0, resp_valid}, 32'd0);
        step();
        check("fl_n1", {31'b0, resp_valid}, 32'd0);
        step();
        check("fl_v", {31'b0, resp_valid}, 32'd1);
        check("fl_d", resp_data, 32'h33);
        check("fl_a", resp_addr, 32'h8);
        step();

        // async reset mid-flight
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        step();
        req_addr   = 32'h4;
        step();
        req_valid = 1'b0;
        step();
        check("ar_pre", {31'b0, resp_valid}, 32'd1);
        #3 reset = 1'b0;
        #1;
        check("ar_v", {31'b0, resp_valid}, 32'd0);
        check("ar_d", resp_data, 32'd0);
        #2 reset = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_stale", {31'b0, resp_valid}, 32'd0);
            check("ar_rdy", {31'b0, req_ready}, 32'd1);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_valid = 1'b0;
        expect_resp("ar_mem", 32'h11, 32'h0, 1'b0);

        // load and fetch of the same word on one edge
        load_en   = 1'b1;
        load_addr = AW'(3);
        load_data = 32'h99;
        req_valid = 1'b1;
        req_addr  = 32'hC;
        step();
        load_en   = 1'b0;
        req_valid = 1'b0;
        expect_resp("ld_old", 32'h44, 32'hC, 1'b0);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        expect_resp("ld_new", 32'h99, 32'hC, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
